// File: rtl/sfu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sfu_pkg
//  Description : Opcode encodings, state type and small decode helpers shared
//                by the sequential function unit and its ALU core.
//  Revision    : 1.0 - initial release
// ============================================================================
package sfu_pkg;

   // Function-select encodings (5-bit G). Logic ops ignore G[0].
   localparam logic [4:0] OP_PASS = 5'b00000;
   localparam logic [4:0] OP_INC  = 5'b00001;
   localparam logic [4:0] OP_ADD  = 5'b00010;
   localparam logic [4:0] OP_ADDC = 5'b00011;
   localparam logic [4:0] OP_SUBB = 5'b00100;
   localparam logic [4:0] OP_SUB  = 5'b00101;
   localparam logic [4:0] OP_DEC  = 5'b00110;
   localparam logic [4:0] OP_AND  = 5'b01000;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_XOR  = 5'b01100;
   localparam logic [4:0] OP_NOT  = 5'b01110;
   localparam logic [4:0] OP_SRL  = 5'b10000;
   localparam logic [4:0] OP_SLL  = 5'b10001;
   localparam logic [4:0] OP_SRA  = 5'b10010;
   localparam logic [4:0] OP_ROR  = 5'b10011;

   // Controller states.
   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   // True for the four real shift opcodes; other 1xxxx codes are pass-through.
   function automatic logic is_shift_op(input logic [4:0] g);
      return (g == OP_SRL) || (g == OP_SLL) || (g == OP_SRA) || (g == OP_ROR);
   endfunction

endpackage : sfu_pkg
`default_nettype wire

// File: rtl/sfu_alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : sfu_alu_core
//  Description : Purely combinational single-cycle ALU: arithmetic group
//                (G[3]=0) and logic group (G[3]=1). Produces result, carry
//                and overflow; shift-group handling lives in the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module sfu_alu_core #(
   parameter int WIDTH = 8
) (
   input  logic [3:0]       g,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_b_op;

   // Arithmetic: A + {0, B, ~B, all-ones} + G[0]; logic ops otherwise.
   always_comb begin
      result = a;
      carry  = 1'b0;
      ovf    = 1'b0;
      w_b_op = '0;
      w_sum  = '0;
      if (!g[3]) begin
         case (g[2:1])
            2'b00:   w_b_op = '0;
            2'b01:   w_b_op = b;
            2'b10:   w_b_op = ~b;
            default: w_b_op = '1;
         endcase
         w_sum = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, g[0]};
         // 0111 is a plain transfer of A with clear flags, not A + all-ones + 1.
         if (g[2:0] != 3'b111) begin
            result = w_sum[WIDTH-1:0];
            carry  = w_sum[WIDTH];
            // Carry into the MSB recovered from the MSB sum bit, XOR carry out.
            ovf    = a[WIDTH-1] ^ w_b_op[WIDTH-1] ^ w_sum[WIDTH-1] ^ w_sum[WIDTH];
         end
      end else begin
         case (g[2:1])
            2'b00:   result = a & b;
            2'b01:   result = a | b;
            2'b10:   result = a ^ b;
            default: result = ~a;
         endcase
      end
   end

endmodule : sfu_alu_core
`default_nettype wire

// File: rtl/sequential_function_unit.sv
`default_nettype none
// ============================================================================
//  Module      : sequential_function_unit
//  Description : Registered function unit with start/busy/done handshake.
//                ALU ops finish in one clock; shift ops walk a separate
//                working register one bit per clock, then write F/flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequential_function_unit
   import sfu_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       G,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SHW-1:0]   SH,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] F,
   output logic             V,
   output logic             C,
   output logic             N,
   output logic             Z
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] work_q,  work_d;
   logic [SHW-1:0]   count_q, count_d;
   logic [1:0]       sop_q,   sop_d;
   logic [WIDTH-1:0] f_q,     f_d;
   logic             v_q,     v_d;
   logic             c_q,     c_d;
   logic             n_q,     n_d;
   logic             z_q,     z_d;
   logic             done_q,  done_d;

   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_c;
   logic             w_alu_v;
   logic [WIDTH-1:0] w_shifted;
   logic             w_shift_out;

   sfu_alu_core #(.WIDTH(WIDTH)) u_alu (
      .g      (G[3:0]),
      .a      (A),
      .b      (B),
      .result (w_alu_res),
      .carry  (w_alu_c),
      .ovf    (w_alu_v)
   );

   // One-bit step of the working register; ROR reports the bit entering the MSB.
   always_comb begin
      w_shifted   = work_q;
      w_shift_out = 1'b0;
      case (sop_q)
         OP_SRL[1:0]: begin
            w_shifted   = {1'b0, work_q[WIDTH-1:1]};
            w_shift_out = work_q[0];
         end
         OP_SLL[1:0]: begin
            w_shifted   = {work_q[WIDTH-2:0], 1'b0};
            w_shift_out = work_q[WIDTH-1];
         end
         OP_SRA[1:0]: begin
            w_shifted   = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            w_shift_out = work_q[0];
         end
         default: begin
            w_shifted   = {work_q[0], work_q[WIDTH-1:1]};
            w_shift_out = work_q[0];
         end
      endcase
   end

   // Next-state, working register, counter and result/flag write logic.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      count_d = count_q;
      sop_d   = sop_q;
      f_d     = f_q;
      v_d     = v_q;
      c_d     = c_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (is_shift_op(G) && (SH != '0)) begin
                  state_d = S_SHIFT;
                  work_d  = A;
                  count_d = SH;
                  sop_d   = G[1:0];
               end else begin
                  done_d = 1'b1;
                  if (G[4]) begin
                     // Zero-length shifts and unused shift-group codes pass A.
                     f_d = A;
                     c_d = 1'b0;
                     v_d = 1'b0;
                  end else begin
                     f_d = w_alu_res;
                     c_d = w_alu_c;
                     v_d = w_alu_v;
                  end
               end
            end
         end
         default: begin
            work_d  = w_shifted;
            count_d = count_q - 1'b1;
            if (count_q == {{(SHW-1){1'b0}}, 1'b1}) begin
               state_d = S_IDLE;
               f_d     = w_shifted;
               c_d     = w_shift_out;
               v_d     = 1'b0;
               done_d  = 1'b1;
            end
         end
      endcase
      // N/Z always track whatever F is about to hold.
      n_d = f_d[WIDTH-1];
      z_d = (f_d == '0);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         count_q <= '0;
         sop_q   <= '0;
         f_q     <= '0;
         v_q     <= 1'b0;
         c_q     <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         count_q <= count_d;
         sop_q   <= sop_d;
         f_q     <= f_d;
         v_q     <= v_d;
         c_q     <= c_d;
         n_q     <= n_d;
         z_q     <= z_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == S_SHIFT);
   assign done = done_q;
   assign F    = f_q;
   assign V    = v_q;
   assign C    = c_q;
   assign N    = n_q;
   assign Z    = z_q;

endmodule : sequential_function_unit
`default_nettype wire

// File: tb/tb_sequential_function_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequential_function_unit
//  Description : Directed self-checking bench for sequential_function_unit
//                at WIDTH=8 and WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequential_function_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8,  start16;
   logic [4:0]  g8,      g16;
   logic [7:0]  a8,  b8;
   logic [15:0] a16, b16;
   logic [2:0]  sh8;
   logic [3:0]  sh16;
   logic        busy8, done8, v8, c8, n8, z8;
   logic        busy16, done16, v16, c16, n16, z16;
   logic [7:0]  f8;
   logic [15:0] f16;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   sequential_function_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .G(g8), .A(a8), .B(b8), .SH(sh8),
      .busy(busy8), .done(done8), .F(f8), .V(v8), .C(c8), .N(n8), .Z(z8)
   );

   sequential_function_unit #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .G(g16), .A(a16), .B(b16), .SH(sh16),
      .busy(busy16), .done(done16), .F(f16), .V(v16), .C(c16), .N(n16), .Z(z16)
   );

   typedef struct {
      logic [4:0] g;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] f;
      logic [3:0] vcnz;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request to the 8-bit unit for exactly one edge.
   task automatic issue8(input logic [4:0] g, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] sh);
      g8 = g; a8 = a; b8 = b; sh8 = sh; start8 = 1'b1;
      step();
      start8 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start8 = 1'b0; start16 = 1'b0;
      g8 = '0; a8 = '0; b8 = '0; sh8 = '0;
      g16 = '0; a16 = '0; b16 = '0; sh16 = '0;
      step(); step();
      n_checks++;
      if ({busy8, done8, f8, v8, c8, n8, z8} !== 14'd0) begin
         n_fails++;
         $display("FAIL reset8: got busy=%b done=%b F=%h VCNZ=%b%b%b%b, want all 0",
                  busy8, done8, f8, v8, c8, n8, z8);
      end
      n_checks++;
      if ({busy16, done16, f16, v16, c16, n16, z16} !== 22'd0) begin
         n_fails++;
         $display("FAIL reset16: got busy=%b done=%b F=%h VCNZ=%b%b%b%b, want all 0",
                  busy16, done16, f16, v16, c16, n16, z16);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_add_overflow();
      issue8(5'b00010, 8'h80, 8'h80, 3'd0);
      n_checks++;
      if ({done8, busy8, f8, v8, c8, n8, z8} !== {1'b1, 1'b0, 8'h00, 4'b1101}) begin
         n_fails++;
         $display("FAIL add_80_80: got done=%b busy=%b F=%h VCNZ=%b%b%b%b, want done=1 busy=0 F=00 VCNZ=1101",
                  done8, busy8, f8, v8, c8, n8, z8);
      end
      step();
      n_checks++;
      if ({done8, f8, v8, c8, n8, z8} !== {1'b0, 8'h00, 4'b1101}) begin
         n_fails++;
         $display("FAIL done_pulse_hold: got done=%b F=%h VCNZ=%b%b%b%b, want done=0 F=00 VCNZ=1101",
                  done8, f8, v8, c8, n8, z8);
      end
   endtask

   // INC then DEC issued on consecutive edges: one result per cycle.
   task automatic test_back_to_back();
      issue8(5'b00001, 8'h7F, 8'h00, 3'd0);
      n_checks++;
      if ({done8, f8, v8, c8, n8, z8} !== {1'b1, 8'h80, 4'b1010}) begin
         n_fails++;
         $display("FAIL inc_7f: got done=%b F=%h VCNZ=%b%b%b%b, want done=1 F=80 VCNZ=1010",
                  done8, f8, v8, c8, n8, z8);
      end
      issue8(5'b00110, 8'h80, 8'h00, 3'd0);
      n_checks++;
      if ({done8, f8, v8, c8, n8, z8} !== {1'b1, 8'h7F, 4'b1100}) begin
         n_fails++;
         $display("FAIL dec_80: got done=%b F=%h VCNZ=%b%b%b%b, want done=1 F=7F VCNZ=1100",
                  done8, f8, v8, c8, n8, z8);
      end
      step();
   endtask

   task automatic test_alu_table();
      vec_t tbl[10];
      tbl[0] = '{5'b01000, 8'h0F, 8'h3C, 8'h0C, 4'b0000};  // AND
      tbl[1] = '{5'b01011, 8'h0F, 8'hA0, 8'hAF, 4'b0010};  // OR (G[0]=1)
      tbl[2] = '{5'b01100, 8'hFF, 8'hFF, 8'h00, 4'b0001};  // XOR
      tbl[3] = '{5'b01110, 8'hFF, 8'h12, 8'h00, 4'b0001};  // NOT
      tbl[4] = '{5'b00101, 8'h05, 8'h07, 8'hFE, 4'b0010};  // SUB with borrow
      tbl[5] = '{5'b00100, 8'h10, 8'h01, 8'h0E, 4'b0100};  // A + ~B
      tbl[6] = '{5'b00011, 8'h7F, 8'h00, 8'h80, 4'b1010};  // A + B + 1
      tbl[7] = '{5'b00111, 8'h80, 8'h55, 8'h80, 4'b0010};  // pass A, flags clear
      tbl[8] = '{5'b10100, 8'h3C, 8'h00, 8'h3C, 4'b0000};  // unused shift code
      tbl[9] = '{5'b00000, 8'h00, 8'hFF, 8'h00, 4'b0001};  // pass zero
      for (int i = 0; i < 10; i++) begin
         issue8(tbl[i].g, tbl[i].a, tbl[i].b, 3'd5);
         n_checks++;
         if ({done8, busy8, f8, v8, c8, n8, z8} !== {1'b1, 1'b0, tbl[i].f, tbl[i].vcnz}) begin
            n_fails++;
            $display("FAIL alu_vec%0d G=%b: got done=%b busy=%b F=%h VCNZ=%b%b%b%b, want done=1 busy=0 F=%h VCNZ=%b",
                     i, tbl[i].g, done8, busy8, f8, v8, c8, n8, z8, tbl[i].f, tbl[i].vcnz);
         end
      end
      step();
   endtask

   // Shift of n bits: busy for n cycles after accept, then done with result.
   task automatic test_shift(input logic [4:0] g, input logic [7:0] a,
                             input logic [2:0] sh, input logic [7:0] exp_f,
                             input logic exp_c);
      issue8(g, a, 8'h00, sh);
      for (int i = 0; i < int'(sh); i++) begin
         n_checks++;
         if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            n_fails++;
            $display("FAIL shift_busy G=%b cyc%0d: got busy=%b done=%b, want busy=1 done=0",
                     g, i, busy8, done8);
         end
         step();
      end
      n_checks++;
      if ({busy8, done8, f8, v8, c8, n8, z8} !==
          {1'b0, 1'b1, exp_f, 1'b0, exp_c, exp_f[7], (exp_f == 8'h00)}) begin
         n_fails++;
         $display("FAIL shift_result G=%b A=%h SH=%0d: got busy=%b done=%b F=%h VCNZ=%b%b%b%b, want busy=0 done=1 F=%h C=%b",
                  g, a, sh, busy8, done8, f8, v8, c8, n8, z8, exp_f, exp_c);
      end
      step();
   endtask

   task automatic test_shifts();
      test_shift(5'b10001, 8'h81, 3'd3, 8'h08, 1'b0);  // SLL
      test_shift(5'b10010, 8'h81, 3'd2, 8'hE0, 1'b0);  // SRA
      test_shift(5'b10011, 8'h01, 3'd1, 8'h80, 1'b1);  // ROR
      test_shift(5'b10000, 8'h5A, 3'd0, 8'h5A, 1'b0);  // SH=0 is single-cycle
   endtask

   // SRL of 5 with an ADD presented mid-shift: the ADD must be dropped.
   task automatic test_ignore_while_busy();
      int dones = 0;
      issue8(5'b10001, 8'h40, 8'h00, 3'd1);  // leaves F=80 before the long shift
      step();
      issue8(5'b10000, 8'hF0, 8'h00, 3'd5);
      step();
      g8 = 5'b00010; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
      step();
      start8 = 1'b0;
      n_checks++;
      if (busy8 !== 1'b1 || f8 !== 8'h80) begin
         n_fails++;
         $display("FAIL hold_during_shift: got busy=%b F=%h, want busy=1 F=80", busy8, f8);
      end
      for (int i = 0; i < 10; i++) begin
         if (done8 === 1'b1) dones++;
         step();
      end
      n_checks++;
      if (dones !== 1) begin
         n_fails++;
         $display("FAIL single_done: got %0d done pulses, want 1", dones);
      end
      n_checks++;
      if ({busy8, f8, v8, c8, n8, z8} !== {1'b0, 8'h07, 4'b0100}) begin
         n_fails++;
         $display("FAIL srl_f0_5: got busy=%b F=%h VCNZ=%b%b%b%b, want busy=0 F=07 VCNZ=0100",
                  busy8, f8, v8, c8, n8, z8);
      end
   endtask

   task automatic test_reset_midshift();
      int dones = 0;
      issue8(5'b10000, 8'hFF, 8'h00, 3'd6);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if ({busy8, done8, f8} !== 10'd0) begin
         n_fails++;
         $display("FAIL reset_abort: got busy=%b done=%b F=%h, want 0 0 00", busy8, done8, f8);
      end
      for (int i = 0; i < 10; i++) begin
         if (done8 === 1'b1) dones++;
         step();
      end
      n_checks++;
      if (dones !== 0 || f8 !== 8'h00) begin
         n_fails++;
         $display("FAIL no_done_after_abort: got %0d done pulses F=%h, want 0 pulses F=00", dones, f8);
      end
   endtask

   task automatic test_width16();
      g16 = 5'b00001; a16 = 16'hFFFF; b16 = 16'h0000; sh16 = 4'd0; start16 = 1'b1;
      step();
      start16 = 1'b0;
      n_checks++;
      if ({done16, f16, v16, c16, n16, z16} !== {1'b1, 16'h0000, 4'b0101}) begin
         n_fails++;
         $display("FAIL w16_inc_ffff: got done=%b F=%h VCNZ=%b%b%b%b, want done=1 F=0000 VCNZ=0101",
                  done16, f16, v16, c16, n16, z16);
      end
      g16 = 5'b01101; a16 = 16'hFFFF; b16 = 16'h000A; start16 = 1'b1;
      step();
      start16 = 1'b0;
      n_checks++;
      if ({done16, f16, v16, c16, n16, z16} !== {1'b1, 16'hFFF5, 4'b0010}) begin
         n_fails++;
         $display("FAIL w16_xor: got done=%b F=%h VCNZ=%b%b%b%b, want done=1 F=FFF5 VCNZ=0010",
                  done16, f16, v16, c16, n16, z16);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_back_to_back();
      test_alu_table();
      test_shifts();
      test_ignore_while_busy();
      test_reset_midshift();
      test_width16();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_sequential_function_unit
`default_nettype wire
